// File: rtl/ceespu_dmem_responder_if.sv
// Purpose : dmem request/response bundle between the ceespu core and its data memory.
// Latency : n/a (wires only).
// Backpressure: O_busy from the memory holds the core; the core keeps its request stable while it is high.
// Signals:
//   I_memE    core -> mem   access request
//   I_memWe   core -> mem   byte write enables (4'b0000 = read)
//   I_address core -> mem   byte address
//   I_wdata   core -> mem   store data
//   O_rdata   mem  -> core  registered read data
//   O_busy    mem  -> core  combinational stall
//   O_err     mem  -> core  one-cycle out-of-range pulse
interface ceespu_dmem_responder_if;
    logic        I_memE;
    logic [3:0]  I_memWe;
    logic [15:0] I_address;
    logic [31:0] I_wdata;
    logic [31:0] O_rdata;
    logic        O_busy;
    logic        O_err;

    modport master (
        output I_memE, I_memWe, I_address, I_wdata,
        input  O_rdata, O_busy, O_err
    );

    modport slave (
        input  I_memE, I_memWe, I_address, I_wdata,
        output O_rdata, O_busy, O_err
    );
endinterface

// File: rtl/ceespu_dmem_responder.sv
// Purpose : word-organised data RAM behind the ceespu dmem port, with programmable wait states.
// Latency : WAIT_STATES+1 cycles from first request cycle to read data valid on O_rdata.
// Backpressure: O_busy = I_memE && (cnt != WAIT_STATES); the core must hold its request while busy.
// Ports:
//   I_clk, I_rst_n        clock, asynchronous active-low reset
//   bus (slave modport)   I_memE / I_memWe / I_address / I_wdata in, O_rdata / O_busy / O_err out
// Optional feature macro: CEESPU_DMEM_ERR_EN
//   defined   : I_address[15:2] >= DEPTH is out of range; writes dropped, reads return ERR_WORD,
//               O_err pulses for the cycle after the completing edge.
//   undefined : upper address bits alias, O_err is tied to 0.
module ceespu_dmem_responder #(
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ERR_WORD    = 32'hDEAD_BEEF
) (
    input  logic                   I_clk,
    input  logic                   I_rst_n,
    ceespu_dmem_responder_if.slave bus
);
    localparam int         AW   = $clog2(DEPTH);
    localparam logic [3:0] LAST = 4'(WAIT_STATES);

    logic [31:0]   r_mem [DEPTH];
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic [31:0]   r_rdata;
    logic          w_busy;
    logic          w_done;
    logic          w_oor;
    logic [AW-1:0] w_index;
    logic          w_unused;

    assign w_index  = bus.I_address[AW+1:2];
    // Byte-offset bits (and aliased upper bits) are intentionally ignored.
    assign w_unused = ^bus.I_address;

    // Wait counter: WAIT while cnt < LAST, DONE when cnt == LAST.
    // Dropping I_memE at any point returns the counter to 0 (abort).
    always_comb begin
        w_cnt_nxt = 4'd0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        if (bus.I_memE) begin
            if (r_cnt == LAST) begin
                w_done = 1'b1;
            end else begin
                w_busy    = 1'b1;
                w_cnt_nxt = r_cnt + 4'd1;
            end
        end
    end

`ifdef CEESPU_DMEM_ERR_EN
    logic r_err;

    assign w_oor = (32'(bus.I_address[15:2]) >= 32'(DEPTH));

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_done && w_oor;
        end
    end

    assign bus.O_err = r_err;
`else
    assign w_oor     = 1'b0;
    assign bus.O_err = 1'b0;
`endif

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_done && (bus.I_memWe == 4'b0000)) begin
                r_rdata <= w_oor ? ERR_WORD : r_mem[w_index];
            end
        end
    end

    // RAM is never cleared. Writes are gated by reset so a request held
    // through reset (possible with WAIT_STATES=0) cannot commit.
    always_ff @(posedge I_clk) begin
        if (I_rst_n && w_done && !w_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.I_memWe[i]) begin
                    r_mem[w_index][8*i +: 8] <= bus.I_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.O_rdata = r_rdata;
    assign bus.O_busy  = w_busy;
endmodule

// File: tb/tb_ceespu_dmem_responder.sv
module tb_ceespu_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n;
    logic rst3_n;

    ceespu_dmem_responder_if bus0 ();
    ceespu_dmem_responder_if bus3 ();

    ceespu_dmem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u0 (
        .I_clk   (clk),
        .I_rst_n (rst0_n),
        .bus     (bus0)
    );

    ceespu_dmem_responder #(.DEPTH(1024), .WAIT_STATES(3)) u3 (
        .I_clk   (clk),
        .I_rst_n (rst3_n),
        .bus     (bus3)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: plain word arrays plus the expected read register.
    logic [31:0] m0 [1024];
    logic [31:0] m3 [1024];
    logic [31:0] exp0;
    logic [31:0] exp3;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic bit is_oor(input logic [15:0] a);
`ifdef CEESPU_DMEM_ERR_EN
        return (a[15:2] >= 14'd1024);
`else
        return (a[15:12] != 4'd15) && 1'b0;
`endif
    endfunction

    // One access on the zero-wait instance; leaves I_memE asserted.
    task automatic step0(input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
        bus0.I_memE = 1'b1; bus0.I_memWe = we; bus0.I_address = a; bus0.I_wdata = d;
        @(posedge clk); #1;
        if (we == 4'b0000) exp0 = is_oor(a) ? 32'hDEAD_BEEF : m0[a[11:2]];
        else if (!is_oor(a)) m0[a[11:2]] = merge(m0[a[11:2]], d, we);
    endtask

    // One access on the 3-wait instance; returns how many busy cycles were seen.
    task automatic acc3(input logic [3:0] we, input logic [15:0] a, input logic [31:0] d,
                        output int nb);
        bus3.I_memE = 1'b1; bus3.I_memWe = we; bus3.I_address = a; bus3.I_wdata = d;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!bus3.O_busy) break;
            nb++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (we == 4'b0000) exp3 = m3[a[11:2]];
        else m3[a[11:2]] = merge(m3[a[11:2]], d, we);
    endtask

    task automatic test_reset;
        bus0.I_memE = 1'b0; bus0.I_memWe = 4'h0; bus0.I_address = 16'h0; bus0.I_wdata = 32'h0;
        bus3.I_memE = 1'b0; bus3.I_memWe = 4'h0; bus3.I_address = 16'h0; bus3.I_wdata = 32'h0;
        rst0_n = 1'b0; rst3_n = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst0_n = 1'b1; rst3_n = 1'b1;
        exp0 = 32'h0; exp3 = 32'h0;
        n_total++; if (bus0.O_rdata !== 32'h0) $display("FAIL reset_rdata0 got %h want 0", bus0.O_rdata); else n_pass++;
        n_total++; if (bus3.O_rdata !== 32'h0) $display("FAIL reset_rdata3 got %h want 0", bus3.O_rdata); else n_pass++;
        n_total++; if (bus0.O_err !== 1'b0) $display("FAIL reset_err got %b want 0", bus0.O_err); else n_pass++;
        step0(4'hF, 16'h0040, 32'hCAFE_F00D);
        step0(4'h0, 16'h0040, 32'h0);
        n_total++; if (bus0.O_rdata !== 32'hCAFE_F00D) $display("FAIL pre_reset_read got %h want cafef00d", bus0.O_rdata); else n_pass++;
        // Assert reset mid-clock with a request pending; outputs clear without an edge.
        #3; rst0_n = 1'b0;
        #1;
        n_total++; if (bus0.O_rdata !== 32'h0) $display("FAIL async_reset_rdata got %h want 0", bus0.O_rdata); else n_pass++;
        n_total++; if (bus0.O_busy !== 1'b0) $display("FAIL async_reset_busy got %b want 0", bus0.O_busy); else n_pass++;
        bus0.I_memE = 1'b0;
        exp0 = 32'h0;
        @(posedge clk); #1; rst0_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        step0(4'hF, 16'h0010, 32'h1234_5678);
        n_total++; if (bus0.O_busy !== 1'b0) $display("FAIL basic_busy_wr got %b want 0", bus0.O_busy); else n_pass++;
        n_total++; if (bus0.O_rdata !== 32'h0) $display("FAIL basic_rdata_after_wr got %h want 0", bus0.O_rdata); else n_pass++;
        step0(4'h0, 16'h0010, 32'h0);
        n_total++; if (bus0.O_rdata !== 32'h1234_5678) $display("FAIL basic_read got %h want 12345678", bus0.O_rdata); else n_pass++;
        n_total++; if (bus0.O_busy !== 1'b0) $display("FAIL basic_busy_rd got %b want 0", bus0.O_busy); else n_pass++;
        bus0.I_memE = 1'b0;
    endtask

    task automatic test_byte_lanes;
        step0(4'hF, 16'h0020, 32'hAABB_CCDD);
        step0(4'b0101, 16'h0020, 32'h1122_3344);
        step0(4'h0, 16'h0022, 32'h0);
        n_total++; if (bus0.O_rdata !== 32'hAA22_CC44) $display("FAIL byte_lanes got %h want aa22cc44", bus0.O_rdata); else n_pass++;
        bus0.I_memE = 1'b0;
    endtask

    task automatic test_random0;
        logic [3:0]  we;
        logic [15:0] a;
        logic [31:0] d;
        for (int w = 0; w < 64; w++) step0(4'hF, 16'(w * 4), $urandom);
        for (int i = 0; i < 150; i++) begin
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            a  = {8'h00, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            d  = $urandom;
            step0(we, a, d);
            n_total++; if (bus0.O_rdata !== exp0) $display("FAIL rand0_rdata op %0d got %h want %h", i, bus0.O_rdata, exp0); else n_pass++;
            n_total++; if (bus0.O_busy !== 1'b0 || bus0.O_err !== 1'b0) $display("FAIL rand0_busy_err op %0d got %b%b want 00", i, bus0.O_busy, bus0.O_err); else n_pass++;
        end
        bus0.I_memE = 1'b0;
    endtask

    task automatic test_alias_err;
        step0(4'hF, 16'h0000, 32'h5555_AAAA);
        step0(4'hF, 16'h1000, 32'h1212_1212);
        step0(4'h0, 16'h0000, 32'h0);
`ifdef CEESPU_DMEM_ERR_EN
        n_total++; if (bus0.O_rdata !== 32'h5555_AAAA) $display("FAIL oor_write_dropped got %h want 5555aaaa", bus0.O_rdata); else n_pass++;
`else
        n_total++; if (bus0.O_rdata !== 32'h1212_1212) $display("FAIL alias_write got %h want 12121212", bus0.O_rdata); else n_pass++;
`endif
        step0(4'h0, 16'h1000, 32'h0);
        n_total++; if (bus0.O_rdata !== exp0) $display("FAIL high_addr_read got %h want %h", bus0.O_rdata, exp0); else n_pass++;
        n_total++; if (bus0.O_err !== is_oor(16'h1000)) $display("FAIL err_pulse got %b want %b", bus0.O_err, is_oor(16'h1000)); else n_pass++;
        bus0.I_memE = 1'b0;
        @(posedge clk); #1;
        n_total++; if (bus0.O_err !== 1'b0) $display("FAIL err_one_cycle got %b want 0", bus0.O_err); else n_pass++;
    endtask

    task automatic test_wait_states;
        int nb;
        acc3(4'hF, 16'h0040, 32'h0F1E_2D3C, nb);
        acc3(4'hF, 16'h0044, 32'h4B5A_6978, nb);
        n_total++; if (nb !== 3) $display("FAIL ws_write_busy got %0d want 3", nb); else n_pass++;
        acc3(4'h0, 16'h0040, 32'h0, nb);
        n_total++; if (nb !== 3) $display("FAIL ws_read_busy got %0d want 3", nb); else n_pass++;
        n_total++; if (bus3.O_rdata !== 32'h0F1E_2D3C) $display("FAIL ws_read_data got %h want 0f1e2d3c", bus3.O_rdata); else n_pass++;
        // Request still held: the next access starts a fresh busy window.
        acc3(4'h0, 16'h0044, 32'h0, nb);
        n_total++; if (nb !== 3) $display("FAIL ws_b2b_busy got %0d want 3", nb); else n_pass++;
        n_total++; if (bus3.O_rdata !== 32'h4B5A_6978) $display("FAIL ws_b2b_data got %h want 4b5a6978", bus3.O_rdata); else n_pass++;
        bus3.I_memE = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort;
        int nb;
        acc3(4'hF, 16'h0080, 32'h0BAD_C0DE, nb);
        bus3.I_memE = 1'b0;
        @(posedge clk); #1;
        bus3.I_memE = 1'b1; bus3.I_memWe = 4'hF; bus3.I_address = 16'h0080; bus3.I_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        n_total++; if (bus3.O_busy !== 1'b1) $display("FAIL abort_busy_mid got %b want 1", bus3.O_busy); else n_pass++;
        bus3.I_memE = 1'b0;
        @(posedge clk); #1;
        acc3(4'h0, 16'h0080, 32'h0, nb);
        n_total++; if (nb !== 3) $display("FAIL abort_fresh_window got %0d want 3", nb); else n_pass++;
        n_total++; if (bus3.O_rdata !== 32'h0BAD_C0DE) $display("FAIL abort_old_word got %h want 0badc0de", bus3.O_rdata); else n_pass++;
        bus3.I_memE = 1'b0;
        @(posedge clk); #1;
        // Reset pulse in the middle of a pending write.
        bus3.I_memE = 1'b1; bus3.I_memWe = 4'hF; bus3.I_address = 16'h0080; bus3.I_wdata = 32'h1111_1111;
        repeat (2) begin @(posedge clk); #1; end
        rst3_n = 1'b0;
        #1;
        exp3 = 32'h0;
        n_total++; if (bus3.O_rdata !== 32'h0) $display("FAIL reset_mid_wait_rdata got %h want 0", bus3.O_rdata); else n_pass++;
        bus3.I_memE = 1'b0;
        @(posedge clk); #1; rst3_n = 1'b1;
        @(posedge clk); #1;
        acc3(4'h0, 16'h0080, 32'h0, nb);
        n_total++; if (nb !== 3) $display("FAIL reset_fresh_window got %0d want 3", nb); else n_pass++;
        n_total++; if (bus3.O_rdata !== 32'h0BAD_C0DE) $display("FAIL reset_no_partial_write got %h want 0badc0de", bus3.O_rdata); else n_pass++;
        bus3.I_memE = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random3;
        int          nb;
        logic [3:0]  we;
        logic [15:0] a;
        for (int w = 0; w < 16; w++) acc3(4'hF, 16'h0200 + 16'(w * 4), $urandom, nb);
        for (int i = 0; i < 30; i++) begin
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            a  = 16'h0200 + {10'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            acc3(we, a, $urandom, nb);
            n_total++; if (nb !== 3) $display("FAIL rand3_busy op %0d got %0d want 3", i, nb); else n_pass++;
            n_total++; if (bus3.O_rdata !== exp3) $display("FAIL rand3_rdata op %0d got %h want %h", i, bus3.O_rdata, exp3); else n_pass++;
        end
        bus3.I_memE = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_byte_lanes;
        test_random0;
        test_alias_err;
        test_wait_states;
        test_abort;
        test_random3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
